// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : systolic_pkg                                              |
// | Brief    : Shared defaults, FSM encoding and flush length for the    |
// |            systolic array input-skew feeder.                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package systolic_pkg;

  localparam int DEF_DATA_SIZE = 2;
  localparam int DEF_N         = 4;

  // Cycles of zero injection after the last slice: the last operand pair
  // needs 2N-2 further cycles to reach the far corner cell (N-1,N-1).
  localparam int DEF_FLUSH_LEN = 2 * DEF_N - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  function automatic int flush_len(input int n);
    return 2 * n - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : skew_delay                                                |
// | Brief    : Reset-clearable shift register of DEPTH stages; DEPTH=0   |
// |            is a plain wire.                                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module skew_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Lane 0 has no extra delay; clock and reset are intentionally idle.
      logic w_unused;
      assign w_unused = clk ^ reset;
      assign dout     = din;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift one stage per cycle; reset empties the whole line.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
        end else begin
          r_stage[0] <= din;
          for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
        end
      end

      assign dout = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : systolic_feeder                                           |
// | Brief    : Input-skew stage for an N x N systolic array. Registers   |
// |            one k-slice per cycle, delays row/column i by i cycles,   |
// |            tags the first slice, zero-fills bubbles and flushes.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int N         = DEF_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   slice_valid,
  output logic                   slice_ready,
  input  logic                   slice_last,
  input  logic [N*DATA_SIZE-1:0] slice_a,
  input  logic [N*DATA_SIZE-1:0] slice_b,
  output logic [N*DATA_SIZE-1:0] a_out,
  output logic [N*DATA_SIZE-1:0] b_out,
  output logic [N-1:0]           a_first,
  output logic [N-1:0]           b_first,
  output logic                   busy,
  output logic                   done
);

  localparam int FLUSH_LEN = flush_len(N);
  localparam int CNT_W     = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_LEN - 1);

  feeder_state_t            r_state;
  feeder_state_t            w_state_nxt;
  logic [CNT_W-1:0]         r_flush_cnt;
  logic                     w_ready_st;
  logic                     w_done;
  logic                     w_xfer;
  logic                     w_first;
  logic [N*DATA_SIZE-1:0]   r_in_a;
  logic [N*DATA_SIZE-1:0]   r_in_b;
  logic                     r_in_first;

  // Ready is decided by state alone; it is only held low while reset is
  // asserted so that every output reads zero during reset.
  assign slice_ready = w_ready_st & reset;
  assign w_xfer      = slice_valid & slice_ready;
  assign w_first     = w_xfer && (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign done        = w_done;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs. IDLE/FEED always offer ready,
  // so slice_valid alone stands for a transfer there (avoids a loop
  // through slice_ready).
  always_comb begin
    w_state_nxt = r_state;
    w_ready_st  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_st = 1'b1;
        if (slice_valid) w_state_nxt = slice_last ? FLUSH : FEED;
      end
      FEED: begin
        w_ready_st = 1'b1;
        if (slice_valid && slice_last) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        if (r_flush_cnt == CNT_LAST) w_state_nxt = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flush counter runs 0..FLUSH_LEN-1 while flushing and rests at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flush_cnt <= '0;
    end else if (r_state == FLUSH) begin
      r_flush_cnt <= (r_flush_cnt == CNT_LAST) ? '0 : r_flush_cnt + 1'b1;
    end else begin
      r_flush_cnt <= '0;
    end
  end

  // Common input register: the slice on a transfer, zeros on any other cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_a     <= '0;
      r_in_b     <= '0;
      r_in_first <= 1'b0;
    end else begin
      r_in_a     <= w_xfer ? slice_a : '0;
      r_in_b     <= w_xfer ? slice_b : '0;
      r_in_first <= w_first;
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_row
      logic [DATA_SIZE:0] w_lane;
      skew_delay #(
        .WIDTH (DATA_SIZE + 1),
        .DEPTH (i)
      ) u_skew (
        .clk   (clk),
        .reset (reset),
        .din   ({r_in_first, r_in_a[i*DATA_SIZE +: DATA_SIZE]}),
        .dout  (w_lane)
      );
      assign a_out[i*DATA_SIZE +: DATA_SIZE] = w_lane[DATA_SIZE-1:0];
      assign a_first[i]                      = w_lane[DATA_SIZE];
    end

    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_SIZE:0] w_lane;
      skew_delay #(
        .WIDTH (DATA_SIZE + 1),
        .DEPTH (j)
      ) u_skew (
        .clk   (clk),
        .reset (reset),
        .din   ({r_in_first, r_in_b[j*DATA_SIZE +: DATA_SIZE]}),
        .dout  (w_lane)
      );
      assign b_out[j*DATA_SIZE +: DATA_SIZE] = w_lane[DATA_SIZE-1:0];
      assign b_first[j]                      = w_lane[DATA_SIZE];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_systolic_feeder                                        |
// | Brief    : Scoreboard bench for systolic_feeder with a behavioural   |
// |            timing model and an N x N multiply-accumulate array model.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_systolic_feeder;

  localparam int DS  = 2;
  localparam int NN  = 4;
  localparam int W   = NN * DS;
  localparam int BIG = 1 << 30;

  typedef logic [NN*NN*16-1:0] cmat_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; bit last; } slice_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          slice_valid = 1'b0;
  logic          slice_ready;
  logic          slice_last = 1'b0;
  logic [W-1:0]  slice_a = '0;
  logic [W-1:0]  slice_b = '0;
  logic [W-1:0]  a_out, b_out;
  logic [NN-1:0] a_first, b_first;
  logic          busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  systolic_feeder #(.DATA_SIZE(DS), .N(NN)) dut (
    .clk         (clk),
    .reset       (reset),
    .slice_valid (slice_valid),
    .slice_ready (slice_ready),
    .slice_last  (slice_last),
    .slice_a     (slice_a),
    .slice_b     (slice_b),
    .a_out       (a_out),
    .b_out       (b_out),
    .a_first     (a_first),
    .b_first     (b_first),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expectations keyed by cycle, plus queues of done events
  // and of the matrix product each done should deliver.
  logic [W-1:0]  exp_a  [int];
  logic [W-1:0]  exp_b  [int];
  logic [NN-1:0] exp_af [int];
  logic [NN-1:0] exp_bf [int];
  bit            exp_ready [int];
  bit            exp_busy  [int];
  int            done_q [$];
  cmat_t         c_q [$];

  // Reference model state (protocol level).
  int            lock_from = -10, lock_to = -10;
  int            busy_from = BIG, busy_to = BIG;
  bit            in_mat = 1'b0;
  logic [W-1:0]  ka [$];
  logic [W-1:0]  kb [$];
  slice_t        sq [$];

  // Array model fed from the DUT outputs.
  logic [W-1:0]  h_a  [int];
  logic [W-1:0]  h_b  [int];
  logic [NN-1:0] h_af [int];
  int            acc [NN][NN];

  function automatic void check_eq(string nm, logic [255:0] act, logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endfunction

  function automatic void put_lane(int c, int i, logic [DS-1:0] av, logic [DS-1:0] bv, logic f);
    logic [W-1:0]  ta, tb;
    logic [NN-1:0] tfa, tfb;
    ta = exp_a.exists(c) ? exp_a[c] : '0;
    tb = exp_b.exists(c) ? exp_b[c] : '0;
    tfa = exp_af.exists(c) ? exp_af[c] : '0;
    tfb = exp_bf.exists(c) ? exp_bf[c] : '0;
    ta[i*DS +: DS] = av;
    tb[i*DS +: DS] = bv;
    tfa[i] = f;
    tfb[i] = f;
    exp_a[c] = ta; exp_b[c] = tb; exp_af[c] = tfa; exp_bf[c] = tfb;
  endfunction

  function automatic cmat_t matmul();
    cmat_t r;
    logic [W-1:0] av, bv;
    int s;
    r = '0;
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++) begin
        s = 0;
        for (int k = 0; k < ka.size(); k++) begin
          av = ka[k];
          bv = kb[k];
          s += int'(av[i*DS +: DS]) * int'(bv[j*DS +: DS]);
        end
        r[(i*NN+j)*16 +: 16] = 16'(s);
      end
    return r;
  endfunction

  // One cycle of stimulus; entered and left #1 after a rising edge.
  task automatic drive_cycle(input bit v, input bit last, input logic [W-1:0] a,
                             input logic [W-1:0] b, output bit took);
    int c;
    bit f;
    c = cyc;
    slice_valid = v;
    slice_last  = last;
    slice_a     = a;
    slice_b     = b;
    exp_ready[c] = !(c >= lock_from && c <= lock_to);
    exp_busy[c]  = (c >= busy_from && c <= busy_to);
    took = v && exp_ready[c];
    if (took) begin
      f = !in_mat;
      if (f) begin
        busy_from = c + 1;
        busy_to   = BIG;
        in_mat    = 1'b1;
        ka.delete();
        kb.delete();
      end
      ka.push_back(a);
      kb.push_back(b);
      for (int i = 0; i < NN; i++) put_lane(c + 1 + i, i, a[i*DS +: DS], b[i*DS +: DS], f);
      if (last) begin
        in_mat    = 1'b0;
        lock_from = c + 1;
        lock_to   = c + 2*NN - 1;
        busy_to   = lock_to;
        done_q.push_back(lock_to);
        c_q.push_back(matmul());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit took;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, '0, took);
  endtask

  task automatic run(input int bub);
    int guard;
    bit took;
    guard = 0;
    while (sq.size() > 0) begin
      if (int'($urandom_range(99)) < bub)
        drive_cycle(1'b0, 1'($urandom), W'($urandom), W'($urandom), took);
      else begin
        drive_cycle(1'b1, sq[0].last, sq[0].a, sq[0].b, took);
        if (took) void'(sq.pop_front());
      end
      guard++;
      if (guard > 4000) begin
        checks++;
        failures++;
        $display("FAIL run_timeout: got %0d slices pending expected 0", sq.size());
        sq.delete();
      end
    end
  endtask

  task automatic add_rand(input int k);
    slice_t s;
    for (int i = 0; i < k; i++) begin
      s.a = W'($urandom);
      s.b = W'($urandom);
      s.last = (i == k - 1);
      sq.push_back(s);
    end
  endtask

  // Slice k of identity: column k of A and row k of B carry a 1 at index k.
  task automatic add_ident(input int k0, input int k1);
    slice_t s;
    for (int k = k0; k <= k1; k++) begin
      s.a = '0;
      s.a[k*DS +: DS] = DS'(1);
      s.b = s.a;
      s.last = (k == NN - 1);
      sq.push_back(s);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    slice_valid = 1'b0;
    done_q.delete();
    c_q.delete();
    lock_from = -10; lock_to = -10;
    busy_from = BIG; busy_to = BIG;
    in_mat = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
  endtask

  // Monitor: compares every visible output on the falling edge.
  always @(negedge clk) begin : mon
    int c;
    logic [W-1:0]  av, bv;
    logic [NN-1:0] af;
    int p;
    bit de;
    cmat_t got, req;
    c = cyc;
    h_a[c] = a_out; h_b[c] = b_out; h_af[c] = a_first;
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++) begin
        av = h_a.exists(c - j) ? h_a[c - j] : '0;
        af = h_af.exists(c - j) ? h_af[c - j] : '0;
        bv = h_b.exists(c - i) ? h_b[c - i] : '0;
        p  = int'(av[i*DS +: DS]) * int'(bv[j*DS +: DS]);
        acc[i][j] = af[i] ? p : acc[i][j] + p;
      end
    if (!reset) begin
      check_eq("rst_a_out", a_out, 0);
      check_eq("rst_b_out", b_out, 0);
      check_eq("rst_a_first", a_first, 0);
      check_eq("rst_b_first", b_first, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_ready", slice_ready, 0);
    end else if (exp_ready.exists(c)) begin
      check_eq("a_out", a_out, exp_a.exists(c) ? exp_a[c] : '0);
      check_eq("b_out", b_out, exp_b.exists(c) ? exp_b[c] : '0);
      check_eq("a_first", a_first, exp_af.exists(c) ? exp_af[c] : '0);
      check_eq("b_first", b_first, exp_bf.exists(c) ? exp_bf[c] : '0);
      check_eq("slice_ready", slice_ready, exp_ready[c]);
      check_eq("busy", busy, exp_busy[c]);
      de = (done_q.size() > 0) && (done_q[0] == c);
      check_eq("done", done, de);
      if (de) begin
        void'(done_q.pop_front());
        req = c_q.pop_front();
        got = '0;
        for (int i = 0; i < NN; i++)
          for (int j = 0; j < NN; j++) got[(i*NN+j)*16 +: 16] = 16'(acc[i][j]);
        check_eq("array_result", got, req);
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    slice_t s;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // Single K=1 slice, A column {3,2,1,1} (element 0 = 1).
    s.a = 8'b11_10_01_01;
    s.b = W'($urandom);
    s.last = 1'b1;
    sq.push_back(s);
    run(0);
    idle(10);

    // Identity x identity, back to back.
    add_ident(0, NN - 1);
    run(0);
    idle(10);

    // Identity again with a two-cycle gap between k=1 and k=2.
    add_ident(0, 1);
    run(0);
    idle(2);
    add_ident(2, NN - 1);
    run(0);
    idle(10);

    // Backpressure and back-to-back: two 3-slice matrices, valid held high.
    add_rand(3);
    add_rand(3);
    run(0);
    idle(10);

    // Reset while flushing; the in-flight result must never complete.
    add_rand(2);
    run(0);
    idle(2);
    apply_reset();
    idle(10);

    // Randomised matrices with bubbles.
    for (int m = 0; m < 25; m++) add_rand(int'($urandom_range(1, 6)));
    run(30);
    idle(12);

    check_eq("pending_done", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
